n64_vinfo_ext: RTL and testbench

// - Front end of the N64 digital video path; sits directly upstream of the de-blur stage.
// - Demultiplexes the 4-phase N64 bus D_i (sync nibble, then R, G, B) into a registered pixel vector.
// - Generates the per-phase counter and the blurry-pixel phase flag.
// - Detects PAL/NTSC (vmode) and 240p/480i (n64_480i) from line counts per frame.

---
 rtl/n64_vinfo_ext.sv | 191 +++++++++++++++++++
 tb/tb_n64_vinfo_ext.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/n64_vinfo_ext.sv
// -----------------------------------------------------------------------------
// n64_vinfo_ext
//
// Front end of the N64 digital video path, directly upstream of the de-blur
// stage. The N64 multiplexes one pixel over four nCLK cycles on D_i: a sync
// nibble (marked by nDSYNC low) followed by R, G and B. This block
//   - demultiplexes the four phases into a registered pixel vector,
//   - exposes the bus phase counter and the blurry-pixel phase flag,
//   - counts lines per frame to detect PAL/NTSC and 240p/480i.
// All logic runs on the falling edge of nCLK.
//
// Parameters
//   color_width_i     width of one colour word on D_i (must be >= 4)
//   PAL_LINE_TH       lines per frame at or above which the mode is PAL
//
// Ports
//   nCLK              in   N64 video clock, logic on negedge
//   nRST              in   synchronous active-low reset
//   nDSYNC            in   low = sync nibble on D_i
//   D_i               in   data bus; sync nibble = {nVSYNC,nCLAMP,nHSYNC,nCSYNC}
//   vdata_o           out  {nVSYNC,nCLAMP,nHSYNC,nCSYNC,R,G,B}, last captured
//   data_cnt          out  bus phase: 00 sync, 01 R, 10 G, 11 B
//   blurry_pixel_pos  out  toggles per pixel, 1 = potential blurry pixel
//   vmode             out  1 = PAL, 0 = NTSC
//   n64_480i          out  1 = 480i, 0 = 240p
//
// Build option
//   VINFO_HYSTERESIS_EN  when defined, vmode and n64_480i only change once
//                        two consecutive frames agree on the new value.
// -----------------------------------------------------------------------------
module n64_vinfo_ext #(
    parameter int         color_width_i = 7,
    parameter logic [9:0] PAL_LINE_TH   = 10'd290
) (
    input  logic                         nCLK,
    input  logic                         nRST,
    input  logic                         nDSYNC,
    input  logic [color_width_i-1:0]     D_i,
    output logic [3*color_width_i+3:0]   vdata_o,
    output logic [1:0]                   data_cnt,
    output logic                         blurry_pixel_pos,
    output logic                         vmode,
    output logic                         n64_480i
);

    localparam int CW      = color_width_i;
    localparam int VW      = 3*CW + 4;
    localparam int IDX_NVS = VW - 1;   // nVSYNC inside vdata
    localparam int IDX_NHS = VW - 3;   // nHSYNC inside vdata

    localparam logic [9:0] LINE_MAX = 10'h3FF;

    // registered state
    logic [VW-1:0] vdata_q,       vdata_d;
    logic [1:0]    cnt_q,         cnt_d;
    logic          bpp_q,         bpp_d;
    logic          vmode_q,       vmode_d;
    logic          ilace_q,       ilace_d;
    logic [9:0]    line_q,        line_d;
    logic          frame_valid_q, frame_valid_d;
    logic          prev_lsb_q,    prev_lsb_d;
`ifdef VINFO_HYSTERESIS_EN
    logic          vmode_pend_q,  vmode_pend_d;
    logic          ilace_pend_q,  ilace_pend_d;
`endif

    // combinational helpers
    logic hs_fall;
    logic vs_fall;
    logic vmode_new;
    logic ilace_new;

    // Edges are only meaningful while a sync nibble is on the bus; compare
    // the incoming nibble against the previously captured one.
    assign hs_fall   = ~nDSYNC & vdata_q[IDX_NHS] & ~D_i[1];
    assign vs_fall   = ~nDSYNC & vdata_q[IDX_NVS] & ~D_i[3];

    // Frame classification uses the line count of the frame that just ended.
    assign vmode_new = (line_q >= PAL_LINE_TH);
    // An interlaced source alternates odd/even line counts frame to frame.
    assign ilace_new = line_q[0] ^ prev_lsb_q;

    always_comb begin
        vdata_d       = vdata_q;
        cnt_d         = cnt_q + 2'd1;
        bpp_d         = bpp_q;
        vmode_d       = vmode_q;
        ilace_d       = ilace_q;
        line_d        = line_q;
        frame_valid_d = frame_valid_q;
        prev_lsb_d    = prev_lsb_q;
`ifdef VINFO_HYSTERESIS_EN
        vmode_pend_d  = vmode_pend_q;
        ilace_pend_d  = ilace_pend_q;
`endif

        // ---- demux ----
        if (!nDSYNC) begin
            cnt_d                 = 2'b01;
            vdata_d[VW-1 -: 4]    = D_i[3:0];
            // A new line always starts on the same pixel phase.
            bpp_d                 = hs_fall | ~bpp_q;
        end else begin
            case (cnt_q)
                2'b01:   vdata_d[3*CW-1 -: CW] = D_i;
                2'b10:   vdata_d[2*CW-1 -: CW] = D_i;
                2'b11:   vdata_d[CW-1   -: CW] = D_i;
                default: ;
            endcase
        end

        // ---- line counter ----
        if (vs_fall) begin
            // The hsync that coincides with vsync is line 1 of the new frame.
            line_d = {9'd0, hs_fall};
        end else if (hs_fall && (line_q != LINE_MAX)) begin
            line_d = line_q + 10'd1;
        end

        // ---- frame classification ----
        if (vs_fall) begin
            prev_lsb_d    = line_q[0];
            frame_valid_d = 1'b1;
`ifdef VINFO_HYSTERESIS_EN
            if (vmode_new == vmode_q) begin
                vmode_pend_d = 1'b0;
            end else if (vmode_pend_q) begin
                vmode_d      = vmode_new;
                vmode_pend_d = 1'b0;
            end else begin
                vmode_pend_d = 1'b1;
            end

            // The first frame after reset has no parity reference.
            if (frame_valid_q) begin
                if (ilace_new == ilace_q) begin
                    ilace_pend_d = 1'b0;
                end else if (ilace_pend_q) begin
                    ilace_d      = ilace_new;
                    ilace_pend_d = 1'b0;
                end else begin
                    ilace_pend_d = 1'b1;
                end
            end
`else
            vmode_d = vmode_new;
            // The first frame after reset has no parity reference.
            if (frame_valid_q) begin
                ilace_d = ilace_new;
            end
`endif
        end
    end

    always_ff @(negedge nCLK) begin
        if (!nRST) begin
            vdata_q       <= {4'hF, {(3*CW){1'b0}}};
            cnt_q         <= 2'b00;
            bpp_q         <= 1'b1;
            vmode_q       <= 1'b0;
            ilace_q       <= 1'b0;
            line_q        <= 10'd0;
            frame_valid_q <= 1'b0;
            prev_lsb_q    <= 1'b0;
`ifdef VINFO_HYSTERESIS_EN
            vmode_pend_q  <= 1'b0;
            ilace_pend_q  <= 1'b0;
`endif
        end else begin
            vdata_q       <= vdata_d;
            cnt_q         <= cnt_d;
            bpp_q         <= bpp_d;
            vmode_q       <= vmode_d;
            ilace_q       <= ilace_d;
            line_q        <= line_d;
            frame_valid_q <= frame_valid_d;
            prev_lsb_q    <= prev_lsb_d;
`ifdef VINFO_HYSTERESIS_EN
            vmode_pend_q  <= vmode_pend_d;
            ilace_pend_q  <= ilace_pend_d;
`endif
        end
    end

    assign vdata_o          = vdata_q;
    assign data_cnt         = cnt_q;
    assign blurry_pixel_pos = bpp_q;
    assign vmode            = vmode_q;
    assign n64_480i         = ilace_q;

endmodule

// File: tb/tb_n64_vinfo_ext.sv
// -----------------------------------------------------------------------------
// tb_n64_vinfo_ext
//
// Drives pixels/lines/frames and random bus traffic into n64_vinfo_ext and
// compares every cycle against a pixel-level reference model. A few literal
// expectations pin the reset values, the demux order and the mode detection.
// Inputs change just after the rising edge, the DUT acts on the falling edge,
// outputs are compared at the next rising edge.
// -----------------------------------------------------------------------------
module tb_n64_vinfo_ext;

    logic        nCLK = 1'b0;
    logic        nRST = 1'b0;
    logic        nDSYNC = 1'b1;
    logic [6:0]  D_i = 7'h0;
    logic [24:0] vdata_o;
    logic [1:0]  data_cnt;
    logic        blurry_pixel_pos;
    logic        vmode;
    logic        n64_480i;

    always #5 nCLK = ~nCLK;

    n64_vinfo_ext #(
        .color_width_i (7),
        .PAL_LINE_TH   (10'd290)
    ) dut (
        .nCLK             (nCLK),
        .nRST             (nRST),
        .nDSYNC           (nDSYNC),
        .D_i              (D_i),
        .vdata_o          (vdata_o),
        .data_cnt         (data_cnt),
        .blurry_pixel_pos (blurry_pixel_pos),
        .vmode            (vmode),
        .n64_480i         (n64_480i)
    );

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // ---------------- reference model ----------------
    logic [3:0] m_sync;
    logic [6:0] m_r, m_g, m_b;
    int         m_phase;       // 0 sync, 1 R, 2 G, 3 B
    bit         m_bpp;
    bit         m_pal;
    bit         m_ilace;
    int         m_lines;
    bit         m_have_frame;
    int         m_last_lines;
    // last computed classification, used for the two-frame agreement rule
    bit         m_last_pal;
    bit         m_last_il;

    task automatic model(input bit rst_n, input bit ds_n, input logic [6:0] d);
        bit hs, vs, pal_now, il_now;
        int n;
        if (!rst_n) begin
            m_sync = 4'hF; m_r = '0; m_g = '0; m_b = '0;
            m_phase = 0; m_bpp = 1; m_pal = 0; m_ilace = 0;
            m_lines = 0; m_have_frame = 0; m_last_lines = 0;
            m_last_pal = 0; m_last_il = 0;
            return;
        end
        hs = !ds_n && m_sync[1] && !d[1];
        vs = !ds_n && m_sync[3] && !d[3];
        if (!ds_n) begin
            m_sync = d[3:0];
            m_bpp  = hs ? 1'b1 : !m_bpp;
        end else begin
            if (m_phase == 1) m_r = d;
            if (m_phase == 2) m_g = d;
            if (m_phase == 3) m_b = d;
        end
        m_phase = ds_n ? (m_phase + 1) % 4 : 1;
        if (vs) begin
            n       = m_lines;
            pal_now = (n >= 290);
            il_now  = (n % 2) != (m_last_lines % 2);
`ifdef VINFO_HYSTERESIS_EN
            if (pal_now != m_pal && m_last_pal == pal_now) m_pal = pal_now;
            m_last_pal = pal_now;
            if (m_have_frame) begin
                if (il_now != m_ilace && m_last_il == il_now) m_ilace = il_now;
                m_last_il = il_now;
            end
`else
            m_pal = pal_now;
            if (m_have_frame) m_ilace = il_now;
`endif
            m_last_lines = n;
            m_have_frame = 1;
            m_lines      = hs ? 1 : 0;
        end else if (hs) begin
            m_lines = (m_lines + 1 > 1023) ? 1023 : m_lines + 1;
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(posedge nCLK) begin
        if (chk_en) begin
            logic [24:0] exp_v;
            exp_v = {m_sync, m_r, m_g, m_b};
            n_vec++;
            if (vdata_o !== exp_v || data_cnt !== 2'(m_phase) ||
                blurry_pixel_pos !== m_bpp || vmode !== m_pal || n64_480i !== m_ilace) begin
                n_err++;
                $display("FAIL cycle t=%0t vdata=%h exp=%h cnt=%0d exp=%0d bpp=%b exp=%b vmode=%b exp=%b 480i=%b exp=%b",
                         $time, vdata_o, exp_v, data_cnt, m_phase, blurry_pixel_pos, m_bpp,
                         vmode, m_pal, n64_480i, m_ilace);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input bit rst_n, input bit ds_n, input logic [6:0] d);
        @(posedge nCLK); #1;
        nRST = rst_n; nDSYNC = ds_n; D_i = d;
        model(rst_n, ds_n, d);
        chk_en = 1'b1;
    endtask

    task automatic settle();
        @(negedge nCLK); #1;
    endtask

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 7'($urandom));
    endtask

    // one pixel: sync nibble then R, G, B
    task automatic pixel(input logic [3:0] sync);
        logic [6:0] d;
        d = 7'($urandom);
        d[3:0] = sync;
        step(1'b1, 1'b0, d);
        step(1'b1, 1'b1, 7'($urandom));
        step(1'b1, 1'b1, 7'($urandom));
        step(1'b1, 1'b1, 7'($urandom));
    endtask

    // sync nibble encodings {nVSYNC,nCLAMP,nHSYNC,nCSYNC}
    localparam logic [3:0] S_IDLE = 4'b1111;
    localparam logic [3:0] S_HS   = 4'b1101;
    localparam logic [3:0] S_VHS  = 4'b0101;

    task automatic lines(input int n);
        for (int i = 0; i < n; i++) begin
            pixel(S_HS);
            pixel(S_IDLE);
        end
    endtask

    // a line that also starts a new frame
    task automatic vs_line();
        pixel(S_VHS);
        pixel(S_IDLE);
        settle();
    endtask

`ifdef VINFO_HYSTERESIS_EN
    localparam bit HYST = 1'b1;
`else
    localparam bit HYST = 1'b0;
`endif

    initial begin
        // ---- reset values ----
        do_reset();
        settle();
        lit("reset_vdata", 32'(vdata_o), 32'h01E0_0000);
        lit("reset_cnt",   32'(data_cnt), 32'd0);
        lit("reset_bpp",   32'(blurry_pixel_pos), 32'd1);
        lit("reset_vmode", 32'(vmode), 32'd0);
        lit("reset_480i",  32'(n64_480i), 32'd0);

        // ---- demux order and latency ----
        step(1'b1, 1'b0, 7'h0F); settle(); lit("demux_cnt_s", 32'(data_cnt), 32'd1);
        step(1'b1, 1'b1, 7'h11); settle(); lit("demux_cnt_r", 32'(data_cnt), 32'd2);
        step(1'b1, 1'b1, 7'h22); settle(); lit("demux_cnt_g", 32'(data_cnt), 32'd3);
        step(1'b1, 1'b1, 7'h33); settle(); lit("demux_cnt_b", 32'(data_cnt), 32'd0);
        lit("demux_vdata", 32'(vdata_o), 32'({4'hF, 7'h11, 7'h22, 7'h33}));

        // ---- pixel phase ----
        pixel(S_HS);   settle(); lit("bpp_p0", 32'(blurry_pixel_pos), 32'd1);
        pixel(S_IDLE); settle(); lit("bpp_p1", 32'(blurry_pixel_pos), 32'd0);
        pixel(S_IDLE); settle(); lit("bpp_p2", 32'(blurry_pixel_pos), 32'd1);
        pixel(S_IDLE); settle(); lit("bpp_p3", 32'(blurry_pixel_pos), 32'd0);
        pixel(S_HS);   settle(); lit("bpp_hs1", 32'(blurry_pixel_pos), 32'd1);
        pixel(S_IDLE);
        pixel(S_IDLE); settle(); lit("bpp_p6", 32'(blurry_pixel_pos), 32'd1);
        pixel(S_HS);   settle(); lit("bpp_hs2", 32'(blurry_pixel_pos), 32'd1);

        // ---- NTSC 240p ----
        do_reset();
        lines(263);
        vs_line(); lit("ntsc_vmode_1", 32'(vmode), 32'd0);
        for (int f = 0; f < 4; f++) begin
            lines(262);
            vs_line();
        end
        lit("ntsc_vmode", 32'(vmode), 32'd0);
        lit("ntsc_480i",  32'(n64_480i), 32'd0);

        // ---- PAL 480i ----
        do_reset();
        lines(312);
        vs_line(); lit("pal_vmode_1", 32'(vmode), HYST ? 32'd0 : 32'd1);
        lines(312);
        vs_line(); lit("pal_480i_2",  32'(n64_480i), HYST ? 32'd0 : 32'd1);
        lit("pal_vmode_2", 32'(vmode), 32'd1);
        lines(311);
        vs_line(); lit("pal_480i_3",  32'(n64_480i), 32'd1);
        lines(312);
        vs_line(); lit("pal_480i_4",  32'(n64_480i), 32'd1);

        // ---- single short frame in a 240p stream ----
        do_reset();
        lines(263);
        vs_line();
        lines(262); vs_line();
        lines(262); vs_line();
        lines(261); vs_line(); lit("glitch_480i_4", 32'(n64_480i), HYST ? 32'd0 : 32'd1);
        lines(262); vs_line(); lit("glitch_480i_5", 32'(n64_480i), 32'd1);
        lines(262); vs_line(); lit("glitch_480i_6", 32'(n64_480i), HYST ? 32'd1 : 32'd0);

        // ---- reset mid-frame: next vsync is a first frame ----
        lines(100);
        do_reset();
        lines(263);
        vs_line(); lit("midrst_480i", 32'(n64_480i), 32'd0);
        lines(262);
        vs_line(); lit("midrst_480i_2", 32'(n64_480i), 32'd0);

        // ---- line counter saturation ----
        do_reset();
        lines(1100);
        vs_line(); lit("sat_vmode_1", 32'(vmode), HYST ? 32'd0 : 32'd1);
        lines(299);
        vs_line(); lit("sat_vmode_2", 32'(vmode), 32'd1);
        lit("sat_480i", 32'(n64_480i), HYST ? 32'd0 : 32'd1);

        // ---- nDSYNC stuck high ----
        for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 7'($urandom));

        // ---- random bus traffic with occasional resets ----
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 199) != 0, $urandom_range(0, 3) != 0, 7'($urandom));

        step(1'b1, 1'b1, 7'h0);
        settle();
        @(posedge nCLK); #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
